// File: rtl/frame_seq_pkg.sv
// Shared types and helpers for the sensor-trace frame sequencer.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BODY
    } state_t;

    localparam logic [31:0] MIN_CPF = 32'd2;
    localparam int          MAX_DW  = 256;

    // Odd body beats carry idle_0, even ones idle_1; callers truncate to their width.
    function automatic logic [MAX_DW-1:0] idle_word(input logic       odd_beat,
                                                    input logic [7:0] idle_0,
                                                    input logic [7:0] idle_1);
        return {(MAX_DW/8){(odd_beat ? idle_0 : idle_1)}};
    endfunction

endpackage

// File: rtl/frame_sequencer.sv
// Frames a sensor sample stream into fixed-length AXI-Stream frames:
// one header beat, then samples or idle filler, TLAST on the final beat.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int DW   = 32,
    parameter int FC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [31:0]     cycles_per_frame,
    input  logic [7:0]      idle_0,
    input  logic [7:0]      idle_1,
    input  logic [31:0]     frame_header,
    input  logic [DW-1:0]   s_tdata,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic            busy,
    output logic [FC_W-1:0] frame_count,
    output logic [FC_W-1:0] idle_count
);

    state_t      state, state_d;
    logic [31:0] cpf_q;
    logic [7:0]  idle0_q, idle1_q;
    logic [31:0] hdr_q;
    logic [31:0] beat;

    logic        load_slot;
    logic        last_out;
    logic [31:0] cpf_clamped;
    logic [31:0] hdr_word;
    logic        latch_cfg, load_hdr, load_body, go_idle, frame_done;

    assign load_slot   = !m_tvalid || m_tready;
    // beat == cpf means every beat of the frame is loaded; only the tlast handshake remains.
    assign last_out    = (beat == cpf_q);
    assign cpf_clamped = (cycles_per_frame < MIN_CPF) ? MIN_CPF : cycles_per_frame;
    assign hdr_word    = latch_cfg ? frame_header : hdr_q;
    assign s_tready    = (state == BODY) && load_slot && !last_out;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        latch_cfg  = 1'b0;
        load_hdr   = 1'b0;
        load_body  = 1'b0;
        go_idle    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    latch_cfg = 1'b1;
                    state_d   = HEADER;
                end
            end
            HEADER: begin
                if (load_slot) begin
                    load_hdr = 1'b1;
                    state_d  = BODY;
                end
            end
            BODY: begin
                if (load_slot) begin
                    if (last_out) begin
                        frame_done = 1'b1;
                        // Restart in the same slot so the next header follows tlast with no gap.
                        if (enable) begin
                            latch_cfg = 1'b1;
                            load_hdr  = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        load_body = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpf_q       <= MIN_CPF;
            idle0_q     <= '0;
            idle1_q     <= '0;
            hdr_q       <= '0;
            beat        <= '0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            frame_count <= '0;
            idle_count  <= '0;
        end else begin
            if (latch_cfg) begin
                cpf_q   <= cpf_clamped;
                idle0_q <= idle_0;
                idle1_q <= idle_1;
                hdr_q   <= frame_header;
            end
            if (load_hdr) begin
                m_tdata  <= DW'(hdr_word);
                m_tvalid <= 1'b1;
                m_tlast  <= 1'b0;
                beat     <= 32'd1;
            end
            if (load_body) begin
                m_tdata  <= s_tvalid ? s_tdata : DW'(idle_word(beat[0], idle0_q, idle1_q));
                m_tvalid <= 1'b1;
                m_tlast  <= (beat == cpf_q - 32'd1);
                beat     <= beat + 32'd1;
                if (!s_tvalid) idle_count <= idle_count + 1'b1;
            end
            if (go_idle) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                beat     <= '0;
            end
            if (frame_done) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed scoreboard bench for frame_sequencer: expected beats are queued
// as frames are requested and checked on every output handshake.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] cycles_per_frame = 32'd4;
    logic [7:0]  idle_0 = 8'h55;
    logic [7:0]  idle_1 = 8'hF0;
    logic [31:0] frame_header = 32'hD4C3B2A1;
    logic [31:0] s_tdata = 32'd1;
    logic        s_tvalid = 1'b1;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        busy;
    logic [31:0] frame_count;
    logic [31:0] idle_count;

    frame_sequencer #(.DW(32), .FC_W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cycles_per_frame(cycles_per_frame), .idle_0(idle_0), .idle_1(idle_1),
        .frame_header(frame_header),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .frame_count(frame_count), .idle_count(idle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        first;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          hdr_seen = 0;
    int          last_pop_cyc = 0;
    logic [31:0] exp_smp = 32'd1;
    logic        take_q = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        stall_q = 1'b0;
    logic [31:0] stall_d = '0;
    logic        stall_l = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample source: advance to the next sample after each accepted one.
    always @(negedge clk) take_q = s_tvalid && s_tready;
    always @(posedge clk) begin
        #1;
        if (take_q) s_tdata = s_tdata + 32'd1;
        if (rand_rdy) m_tready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor: stall stability and scoreboard pop on every handshake.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (stall_q) begin
            chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
            chk("stall_data", m_tdata, stall_d);
            chk("stall_last", {31'd0, m_tlast}, {31'd0, stall_l});
        end
        stall_q = !reset && m_tvalid && !m_tready;
        stall_d = m_tdata;
        stall_l = m_tlast;
        if (!reset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_tdata, 32'hDEAD_BEEF ^ m_tdata ^ 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_tdata, e.data);
                chk("beat_last", {31'd0, m_tlast}, {31'd0, e.last});
                if (e.first) hdr_seen++;
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic push_frame(input logic [31:0] cpf, input logic [31:0] hdr, input logic smp,
                              input logic [7:0] i0, input logic [7:0] i1);
        beat_t       b;
        logic [31:0] c;
        c = (cpf < 32'd2) ? 32'd2 : cpf;
        b.data = hdr; b.last = 1'b0; b.first = 1'b1;
        exp_q.push_back(b);
        for (int k = 1; k < int'(c); k++) begin
            if (smp) begin
                b.data  = exp_smp;
                exp_smp = exp_smp + 32'd1;
            end else begin
                b.data = (k % 2 == 1) ? {4{i0}} : {4{i1}};
            end
            b.last  = (k == int'(c) - 1);
            b.first = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_hdr(input int target, input int maxcyc);
        int i;
        for (i = 0; i < maxcyc; i++) begin
            @(negedge clk); #1;
            if (hdr_seen >= target) break;
        end
        if (i == maxcyc) chk("hdr_timeout", hdr_seen, target);
    endtask

    task automatic wait_idle(input int maxcyc);
        int i;
        for (i = 0; i < maxcyc; i++) begin
            @(negedge clk); #1;
            if (!busy && !m_tvalid && exp_q.size() == 0) break;
        end
        if (i == maxcyc) chk("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic run_frames(input int n);
        int base;
        base = hdr_seen;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= n; k++) wait_hdr(base + k, 3000);
        enable = 1'b0;
        wait_idle(3000);
    endtask

    initial begin
        int c0;
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_idle_count", idle_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // cpf=4, streaming samples, back-to-back frames, latency
        push_frame(32'd4, 32'hD4C3B2A1, 1'b1, 8'h55, 8'hF0);
        push_frame(32'd4, 32'hD4C3B2A1, 1'b1, 8'h55, 8'hF0);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("lat_n_valid", {31'd0, m_tvalid}, 32'd0);
        chk("lat_n_busy", {31'd0, busy}, 32'd1);
        chk("lat_n_s_tready", {31'd0, s_tready}, 32'd0);
        @(posedge clk); #1;
        chk("lat_n1_valid", {31'd0, m_tvalid}, 32'd1);
        chk("lat_n1_header", m_tdata, 32'hD4C3B2A1);
        c0 = cyc;
        wait_hdr(2, 100);
        chk("fc_after_first_tlast", frame_count, 32'd1);
        enable = 1'b0;
        wait_idle(100);
        chk("utilisation", last_pop_cyc - c0, 32'd8);
        chk("fc_a", frame_count, 32'd2);

        // Idle filler, cpf=32
        cycles_per_frame = 32'd32;
        frame_header     = 32'hA5A50001;
        s_tvalid         = 1'b0;
        push_frame(32'd32, 32'hA5A50001, 1'b0, 8'h55, 8'hF0);
        run_frames(1);
        chk("idle_count_b", idle_count, 32'd31);
        chk("fc_b", frame_count, 32'd3);

        // Random backpressure with streaming samples
        s_tvalid         = 1'b1;
        cycles_per_frame = 32'd5;
        frame_header     = 32'h0000C0DE;
        for (int f = 0; f < 4; f++) push_frame(32'd5, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        rand_rdy = 1'b1;
        run_frames(4);
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        m_tready = 1'b1;
        chk("fc_c", frame_count, 32'd7);
        chk("idle_count_c", idle_count, 32'd31);

        // cpf 8 -> 6 mid-frame
        cycles_per_frame = 32'd8;
        push_frame(32'd8, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        push_frame(32'd6, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        @(negedge clk);
        enable = 1'b1;
        wait_hdr(hdr_seen + 1, 100);
        cycles_per_frame = 32'd6;
        wait_hdr(hdr_seen + 1, 100);
        enable = 1'b0;
        wait_idle(100);
        chk("fc_d", frame_count, 32'd9);

        // cpf=0 and cpf=1 clamp to 2-beat frames
        cycles_per_frame = 32'd0;
        push_frame(32'd0, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        run_frames(1);
        cycles_per_frame = 32'd1;
        push_frame(32'd1, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        run_frames(1);
        chk("fc_clamp", frame_count, 32'd11);

        // enable dropped early in a cpf=10 frame
        cycles_per_frame = 32'd10;
        push_frame(32'd10, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        @(negedge clk);
        enable = 1'b1;
        wait_hdr(hdr_seen + 1, 100);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_idle(100);
        chk("e_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("e_no_header", {31'd0, m_tvalid}, 32'd0);
        chk("fc_e", frame_count, 32'd12);

        // Reset mid-frame, then restart
        push_frame(32'd10, 32'h0000C0DE, 1'b1, 8'h55, 8'hF0);
        @(negedge clk);
        enable = 1'b1;
        wait_hdr(hdr_seen + 1, 100);
        repeat (4) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("f_valid", {31'd0, m_tvalid}, 32'd0);
        chk("f_tlast", {31'd0, m_tlast}, 32'd0);
        chk("f_busy", {31'd0, busy}, 32'd0);
        chk("f_frame_count", frame_count, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset   = 1'b0;
        exp_smp = s_tdata;
        cycles_per_frame = 32'd3;
        frame_header     = 32'h12345678;
        push_frame(32'd3, 32'h12345678, 1'b1, 8'h55, 8'hF0);
        run_frames(1);
        chk("f_restart_fc", frame_count, 32'd1);
        chk("f_idle_count", idle_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
